// File: rtl/ascii_write_arbiter.sv
// Write-port arbiter for the ascii master RAM: round-robin between requesters A and B,
// plus a full-screen clear engine. Optional `ASCII_ARB_STATS_EN adds an out-of-range drop counter.
module ascii_write_arbiter #(
  parameter int unsigned          ADDR_W     = 13,
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          CELLS      = 4800,
  parameter logic [DATA_W-1:0]    CLEAR_WORD = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_gnt_o,
  input  logic              b_req_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_gnt_o,
  input  logic              clear_start_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
`ifdef ASCII_ARB_STATS_EN
  output logic [15:0]       oob_count_o,
`endif
  output logic              ascii_write_en_o,
  output logic [ADDR_W-1:0] ascii_write_address_o,
  output logic [DATA_W-1:0] ascii_input_o
);

  localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(CELLS - 1);

  typedef enum logic [1:0] {StIdle, StClear, StFinish} state_e;

  state_e              state_q;
  logic                last_b_q;  // 1 when B held the most recent grant
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                busy_q;
  logic                done_q;
`ifdef ASCII_ARB_STATS_EN
  logic [15:0]         oob_q;
`endif

  logic arb_ok;
  logic a_in_range;
  logic b_in_range;

  always_comb begin
    arb_ok     = (state_q == StIdle) && !clear_start_i;
    a_gnt_o    = arb_ok && a_req_i && (!b_req_i || last_b_q);
    b_gnt_o    = arb_ok && b_req_i && (!a_req_i || !last_b_q);
    a_in_range = (a_addr_i <= LastCell);
    b_in_range = (b_addr_i <= LastCell);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      clr_cnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ASCII_ARB_STATS_EN
      oob_q     <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear_start_i) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end else if (a_gnt_o || b_gnt_o) begin
            last_b_q <= b_gnt_o;
            // Out-of-range grants are consumed but never reach the RAM
            if (a_gnt_o ? a_in_range : b_in_range) begin
              we_q   <= 1'b1;
              addr_q <= a_gnt_o ? a_addr_i : b_addr_i;
              data_q <= a_gnt_o ? a_data_i : b_data_i;
            end
`ifdef ASCII_ARB_STATS_EN
            else if (oob_q != 16'hFFFF) begin
              oob_q <= oob_q + 16'd1;
            end
`endif
          end
        end
        StClear: begin
          we_q   <= 1'b1;
          addr_q <= clr_cnt_q;
          data_q <= CLEAR_WORD;
          if (clr_cnt_q == LastCell) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign clear_busy_o          = busy_q;
  assign clear_done_o          = done_q;
  assign ascii_write_en_o      = we_q;
  assign ascii_write_address_o = addr_q;
  assign ascii_input_o         = data_q;
`ifdef ASCII_ARB_STATS_EN
  assign oob_count_o           = oob_q;
`endif

endmodule

// File: tb/tb_ascii_write_arbiter.sv
// Scoreboard bench for ascii_write_arbiter: a bench-side arbiter model pushes expected writes,
// a negedge monitor pops and compares them against the registered write port.
module tb_ascii_write_arbiter;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CELLS  = 4800;

  logic              clk;
  logic              rst;
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_gnt;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_gnt;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
`ifdef ASCII_ARB_STATS_EN
  logic [15:0]       oob_count;
`endif

  ascii_write_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CELLS      (CELLS),
    .CLEAR_WORD (32'h0000_0020)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .a_req_i               (a_req),
    .a_addr_i              (a_addr),
    .a_data_i              (a_data),
    .a_gnt_o               (a_gnt),
    .b_req_i               (b_req),
    .b_addr_i              (b_addr),
    .b_data_i              (b_data),
    .b_gnt_o               (b_gnt),
    .clear_start_i         (clear_start),
    .clear_busy_o          (clear_busy),
    .clear_done_o          (clear_done),
`ifdef ASCII_ARB_STATS_EN
    .oob_count_o           (oob_count),
`endif
    .ascii_write_en_o      (we),
    .ascii_write_address_o (waddr),
    .ascii_input_o         (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard of expected {addr, data} writes, in issue order.
  logic [ADDR_W+DATA_W-1:0] sb[$];
  int busy_cnt = 0;
  int done_cnt = 0;
  logic m_last_b = 1'b1;
  int m_oob = 0;

  always @(negedge clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    if (clear_busy) busy_cnt++;
    if (clear_done) done_cnt++;
    if (we) begin
      if (sb.size() == 0) begin
        check_val("spurious_write", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_val("wr_addr", 32'(waddr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        check_val("wr_data", wdata, e[DATA_W-1:0]);
      end
    end
  end

  task automatic drive_ab(input logic ar, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                          input logic br, input logic [ADDR_W-1:0] ba,
                          input logic [DATA_W-1:0] bd);
    logic ea, eb;
    @(negedge clk);
    a_req = ar; a_addr = aa; a_data = ad;
    b_req = br; b_addr = ba; b_data = bd;
    clear_start = 1'b0;
    #1;
    ea = ar && (!br || m_last_b);
    eb = br && (!ar || !m_last_b);
    check_val("a_gnt", 32'(a_gnt), 32'(ea));
    check_val("b_gnt", 32'(b_gnt), 32'(eb));
    if (ea) begin
      m_last_b = 1'b0;
      if (aa < CELLS) sb.push_back({aa, ad}); else m_oob++;
    end else if (eb) begin
      m_last_b = 1'b1;
      if (ba < CELLS) sb.push_back({ba, bd}); else m_oob++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_ab(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Full clear with A optionally requesting from the clear_start cycle onwards.
  task automatic run_clear(input logic a_hold);
    int viol;
    int done0;
    bit seen;
    viol = 0;
    seen = 0;
    done0 = done_cnt;
    @(negedge clk);
    clear_start = 1'b1;
    a_req = a_hold; a_addr = 13'd9; a_data = 32'h0000_0066;
    b_req = 1'b0;
    #1;
    busy_cnt = 0;
    check_val("gnt_on_clear_start", 32'(a_gnt | b_gnt), 32'd0);
    for (int i = 0; i < CELLS; i++) sb.push_back({ADDR_W'(i), 32'h0000_0020});
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      clear_start = (c == 5);  // ignored while clearing
      #1;
      if (a_gnt || b_gnt) viol++;
      if (clear_done) begin
        seen = 1;
        break;
      end
    end
    clear_start = 1'b0;
    check_val("clear_done_seen", 32'(seen), 32'd1);
    check_val("gnt_during_clear", 32'(viol), 32'd0);
    check_val("busy_cycles", 32'(busy_cnt), CELLS);
    check_val("sb_drained_after_clear", 32'(sb.size()), 32'd0);
    if (a_hold) drive_ab(1'b1, 13'd9, 32'h0000_0066, 1'b0, '0, '0);
    idle_cycles(2);
    check_val("done_pulses", 32'(done_cnt - done0), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    a_req = 0; a_addr = '0; a_data = '0;
    b_req = 0; b_addr = '0; b_data = '0;
    clear_start = 0;
    repeat (2) @(negedge clk);
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_addr", 32'(waddr), 32'd0);
    check_val("rst_data", wdata, 32'd0);
    check_val("rst_busy", 32'(clear_busy), 32'd0);
    check_val("rst_done", 32'(clear_done), 32'd0);
`ifdef ASCII_ARB_STATS_EN
    check_val("rst_oob", 32'(oob_count), 32'd0);
`endif
    rst = 1'b1;

    // Round-robin from reset: A first, then alternate.
    for (int i = 0; i < 4; i++) drive_ab(1'b1, 13'd10, 32'hAAAA_0001, 1'b1, 13'd20, 32'hBBBB_0002);
    // A alone.
    drive_ab(1'b1, 13'd5, 32'h0000_0041, 1'b0, '0, '0);
    idle_cycles(2);
    check_val("sb_drained_basic", 32'(sb.size()), 32'd0);

    // Out-of-range and boundary addresses.
    drive_ab(1'b1, 13'd4800, 32'h0000_0077, 1'b0, '0, '0);
    drive_ab(1'b0, '0, '0, 1'b1, 13'd4799, 32'h0000_0078);
    idle_cycles(2);
`ifdef ASCII_ARB_STATS_EN
    check_val("oob_count", 32'(oob_count), 32'(m_oob));
`endif

    // Random traffic, occasionally out of range.
    for (int i = 0; i < 60; i++) begin
      logic ar, br;
      logic [ADDR_W-1:0] aa, ba;
      ar = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      aa = ADDR_W'($urandom_range(0, 4810));
      ba = ADDR_W'($urandom_range(0, 4810));
      drive_ab(ar, aa, $urandom, br, ba, $urandom);
    end
    idle_cycles(2);
    check_val("sb_drained_random", 32'(sb.size()), 32'd0);

    // Clear with A racing clear_start and held throughout.
    run_clear(1'b1);

    // Reset in the middle of a clear.
    begin
      bit hit;
      int done0;
      hit = 0;
      @(negedge clk);
      a_req = 0; b_req = 0; clear_start = 1'b1;
      for (int i = 0; i < CELLS; i++) sb.push_back({ADDR_W'(i), 32'h0000_0020});
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        if (we && waddr == 13'd100) begin
          hit = 1;
          break;
        end
      end
      check_val("clear_reached_100", 32'(hit), 32'd1);
      rst = 1'b0;
      #1;
      check_val("arst_we", 32'(we), 32'd0);
      check_val("arst_busy", 32'(clear_busy), 32'd0);
      check_val("arst_addr", 32'(waddr), 32'd0);
      sb.delete();
      m_last_b = 1'b1;
      m_oob = 0;
      done0 = done_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle_cycles(8);
      check_val("no_done_after_abort", 32'(done_cnt - done0), 32'd0);
      check_val("busy_after_abort", 32'(clear_busy), 32'd0);
      drive_ab(1'b1, 13'd4799, 32'h1234_5678, 1'b0, '0, '0);
      drive_ab(1'b1, 13'd3, 32'h0000_0033, 1'b1, 13'd4, 32'h0000_0044);
      drive_ab(1'b1, 13'd3, 32'h0000_0033, 1'b1, 13'd4, 32'h0000_0044);
      idle_cycles(2);
      check_val("sb_drained_post_reset", 32'(sb.size()), 32'd0);
`ifdef ASCII_ARB_STATS_EN
      check_val("oob_after_reset", 32'(oob_count), 32'(m_oob));
`endif
    end

    // Plain clear with no competing requester.
    run_clear(1'b0);
    idle_cycles(2);
    check_val("sb_final", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
